jtsdram_bank_chk: RTL

Per-bank read-back checker for the SDRAM test. One instance per SDRAM bank answers the sequencer's read-pass handshake. On a `start` pulse it latches the 5-bit bank key and reads `COUNT` consecutive words from that bank's SDRAM controller port. It compares each word against the pattern the programming pass wrote, then raises `done` so the sequencer can advance its LFSR.

---
 rtl/jtsdram_bank_chk_if.sv | 26 ++
 rtl/jtsdram_bank_chk.sv | 104 ++++++++++
 2 files changed

// File: rtl/jtsdram_bank_chk_if.sv
// rtl/jtsdram_bank_chk_if.sv - SDRAM controller bank read port
interface jtsdram_bank_chk_if #(
    parameter int AW = 22
);
    logic          ba_rd;
    logic [AW-1:0] ba_addr;
    logic          ba_ack;
    logic          ba_rdy;
    logic [15:0]   ba_din;

    modport master (
        output ba_rd,
        output ba_addr,
        input  ba_ack,
        input  ba_rdy,
        input  ba_din
    );

    modport slave (
        input  ba_rd,
        input  ba_addr,
        output ba_ack,
        output ba_rdy,
        output ba_din
    );
endinterface

// File: rtl/jtsdram_bank_chk.sv
// rtl/jtsdram_bank_chk.sv - per-bank SDRAM read-back checker
module jtsdram_bank_chk #(
    parameter int AW    = 22,
    parameter int BANK  = 0,
    parameter int COUNT = 256,
    parameter int TOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           key,
    input  logic                 start,
    output logic                 done,
    jtsdram_bank_chk_if.master   ba,
    output logic                 err,
    output logic                 tout,
    output logic [7:0]           err_cnt,
    output logic [AW-1:0]        bad_addr
);
    localparam int         IW     = AW - 5;
    localparam logic [IW-1:0] LAST   = IW'(COUNT - 1);
    localparam logic [7:0] TOUT_B = 8'(TOUT);
    localparam logic [1:0] BANK_B = 2'(BANK);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

    state_t        state, nxt;
    logic [4:0]    key_r;
    logic [IW-1:0] idx;
    logic [7:0]    wd;
    logic          busy, accept, got, expire, last, mismatch;
    logic [15:0]   expected;

    assign ba.ba_addr = {key_r, idx};
    assign busy     = (state == S_REQ) || (state == S_WAIT);
    assign accept   = ((state == S_IDLE) || (state == S_FIN)) && start;
    assign got      = ((state == S_REQ) && ba.ba_ack && ba.ba_rdy) ||
                      ((state == S_WAIT) && ba.ba_rdy);
    // A word arriving on the final watchdog cycle still counts as a response.
    assign expire   = busy && !got && (wd == TOUT_B);
    assign last     = (idx == LAST);
    assign expected = {ba.ba_addr[7:0], ~ba.ba_addr[15:8]} ^ {BANK_B, 14'b0};
    assign mismatch = (ba.ba_din != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_FIN: if (start) nxt = S_REQ;
            S_REQ: begin
                if (got)           nxt = last ? S_FIN : S_REQ;
                else if (expire)   nxt = S_FIN;
                else if (ba.ba_ack) nxt = S_WAIT;
            end
            S_WAIT: begin
                if (got)         nxt = last ? S_FIN : S_REQ;
                else if (expire) nxt = S_FIN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done     = (state == S_FIN);
        ba.ba_rd = (state == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r    <= '0;
            idx      <= '0;
            wd       <= '0;
            err      <= 1'b0;
            tout     <= 1'b0;
            err_cnt  <= '0;
            bad_addr <= '0;
        end else begin
            if (accept) begin
                key_r <= key;
                idx   <= '0;
                wd    <= '0;
            end else if (got) begin
                wd <= '0;
                if (!last) idx <= idx + 1'b1;
            end else if (busy) begin
                wd <= wd + 8'd1;
            end

            if (got && mismatch) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (!err) bad_addr <= ba.ba_addr;
            end

            if (expire) begin
                tout <= 1'b1;
                err  <= 1'b1;
            end
        end
    end
endmodule
